// File: rtl/addsub_pkg.sv
// addsub_pkg
// Shared definitions for the byte-serial add/subtract sequencer.
//   addsub_state_t : sequencer state encoding (IDLE, RUN, DONE)
//   BYTE_W         : width of one adder slice
package addsub_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } addsub_state_t;

endpackage

// File: rtl/addsub_seq_ctrl_prefixadder.sv
// prefixadder_8bit
// 8-bit Kogge-Stone parallel-prefix adder with carry-in.
// Ports:
//   a, b  in  8  addend bytes
//   cin   in  1  carry into bit 0
//   sum   out 8  a + b + cin, modulo 256
//   cout  out 1  carry out of bit 7
module prefixadder_8bit
    import addsub_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [BYTE_W:0]   c;

    // Bit-level generate/propagate. Using XOR as propagate is safe here
    // because wherever XOR and OR differ, generate is already 1.
    assign g0 = a & b;
    assign p0 = a ^ b;

    // Three prefix levels with spans 1, 2 and 4. Shifted-in propagate
    // bits are 1 and generate bits 0, so the low positions pass through.
    assign g1 = g0 | (p0 & {g0[6:0], 1'b0});
    assign p1 = p0 & {p0[6:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[5:0], 2'b00});
    assign p2 = p1 & {p1[5:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[3:0], 4'b0000});
    assign p3 = p2 & {p2[3:0], 4'b1111};

    // After the prefix tree, g3/p3 bit i covers bits i..0, so folding
    // in cin gives the carry into bit i+1 directly.
    assign c    = {g3 | (p3 & {BYTE_W{cin}}), cin};
    assign sum  = p0 ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/addsub_seq_ctrl.sv
// addsub_seq_ctrl
// Performs a WORDS x 8-bit add or subtract one byte per cycle through a
// single 8-bit prefix adder, least-significant byte first, chaining the
// carry through a register. Produces carry, signed overflow and zero.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand request handshake
//   op_a, op_b, sub      operands; sub=1 computes op_a - op_b
//   out_valid / out_ready result handshake
//   result               sum or difference modulo 2^W
//   carry                MSB carry-out (for subtract, 1 = no borrow)
//   overflow             two's-complement signed overflow
//   zero                 result == 0
//   busy                 operation in flight or awaiting drain
module addsub_seq_ctrl
    import addsub_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int W     = 8 * WORDS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         zero,
    output logic         busy
);

    localparam int IDX_W = $clog2(WORDS);

    addsub_state_t state, state_nxt;
    logic [IDX_W-1:0]  idx, idx_nxt;
    logic [W-1:0]      a_reg, a_nxt;
    logic [W-1:0]      b_reg, b_nxt;
    logic [W-1:0]      res_reg, res_nxt;
    logic              cin_reg, cin_nxt;
    logic              carry_reg, carry_nxt;
    logic              ovf_reg, ovf_nxt;

    logic [BYTE_W-1:0] a_byte, b_byte, sum_byte;
    logic              cout;

    // The single shared adder slice; fed by the byte-select muxes below.
    prefixadder_8bit u_adder (
        .a    (a_byte),
        .b    (b_byte),
        .cin  (cin_reg),
        .sum  (sum_byte),
        .cout (cout)
    );

    // State register and datapath registers. Reset clears everything so a
    // partially computed result can never be presented afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            cin_reg   <= 1'b0;
            carry_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            a_reg     <= a_nxt;
            b_reg     <= b_nxt;
            res_reg   <= res_nxt;
            cin_reg   <= cin_nxt;
            carry_reg <= carry_nxt;
            ovf_reg   <= ovf_nxt;
        end
    end

    // Next-state, datapath updates and output decode. Handshake outputs
    // depend only on registered state (and the reset pin), never on
    // in_valid or out_ready.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        a_nxt     = a_reg;
        b_nxt     = b_reg;
        res_nxt   = res_reg;
        cin_nxt   = cin_reg;
        carry_nxt = carry_reg;
        ovf_nxt   = ovf_reg;

        a_byte = a_reg[BYTE_W*idx +: BYTE_W];
        b_byte = b_reg[BYTE_W*idx +: BYTE_W];

        in_ready  = rst_n && (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        result    = res_reg;
        carry     = carry_reg;
        overflow  = ovf_reg;
        zero      = (res_reg == '0);

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is a + ~b + 1: invert b once here and seed
                    // the carry chain with sub.
                    a_nxt     = op_a;
                    b_nxt     = op_b ^ {W{sub}};
                    cin_nxt   = sub;
                    idx_nxt   = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                res_nxt[BYTE_W*idx +: BYTE_W] = sum_byte;
                cin_nxt = cout;
                if (idx == IDX_W'(WORDS - 1)) begin
                    // Top byte: capture final flags; b_byte is already
                    // inverted for subtract, so one overflow rule serves both.
                    carry_nxt = cout;
                    ovf_nxt   = (a_byte[BYTE_W-1] == b_byte[BYTE_W-1]) &&
                                (sum_byte[BYTE_W-1] != a_byte[BYTE_W-1]);
                    idx_nxt   = '0;
                    state_nxt = DONE;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// tb_addsub_seq_ctrl
// Self-checking bench for addsub_seq_ctrl with WORDS=4: directed table of
// corner-case vectors, backpressure and mid-operation reset sequences, and
// randomized operations checked against an arithmetic reference model.
module tb_addsub_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         carry;
    logic         overflow;
    logic         zero;
    logic         busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        logic [W-1:0] r;
        logic         c;
        logic         o;
        logic         z;
    } vec_t;

    vec_t vecs[5];

    addsub_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Single comparison: counts it and reports a FAIL line on mismatch.
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model from the arithmetic definition of add/subtract.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         output vec_t v);
        logic [W:0] wide;
        v.a = a;
        v.b = b;
        v.s = s;
        if (s) begin
            v.r = a - b;
            v.c = (a >= b);
            v.o = (a[W-1] != b[W-1]) && (v.r[W-1] != a[W-1]);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            v.r = wide[W-1:0];
            v.c = wide[W];
            v.o = (a[W-1] == b[W-1]) && (v.r[W-1] != a[W-1]);
        end
        v.z = (v.r == '0);
    endtask

    // Presents a request, waits for acceptance, then scrambles the inputs
    // and counts cycles until out_valid (cycle after accept edge = 1).
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, output int lat, output bit ok);
        int budget;
        ok = 1'b1;
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        sub  = s;
        budget = 0;
        while (!in_ready && budget < 30) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            ok = 1'b0;
            in_valid = 1'b0;
            lat = 0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        sub  = 1'($urandom_range(0, 1));
        lat = 1;
        while (!out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) begin
            check("out_valid_timeout", 0, 1);
            ok = 1'b0;
        end
    endtask

    // Compares the presented result/flags against the expected record.
    task automatic checkOutput(input vec_t v, input string tag);
        check({tag, "_result"},   result,   v.r);
        check({tag, "_carry"},    W'(carry),    W'(v.c));
        check({tag, "_overflow"}, W'(overflow), W'(v.o));
        check({tag, "_zero"},     W'(zero),     W'(v.z));
    endtask

    // Completes the output handshake and confirms the return to IDLE.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_drain_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_drain_in_ready"},  W'(in_ready),  W'(1));
    endtask

    initial begin : main
        int   lat;
        bit   ok;
        vec_t v, v2;

        vecs[0] = '{a:32'h000000FF, b:32'h00000001, s:1'b0, r:32'h00000100, c:1'b0, o:1'b0, z:1'b0};
        vecs[1] = '{a:32'hFFFFFFFF, b:32'h00000001, s:1'b0, r:32'h00000000, c:1'b1, o:1'b0, z:1'b1};
        vecs[2] = '{a:32'h7FFFFFFF, b:32'h00000001, s:1'b0, r:32'h80000000, c:1'b0, o:1'b1, z:1'b0};
        vecs[3] = '{a:32'h80000000, b:32'h00000001, s:1'b1, r:32'h7FFFFFFF, c:1'b1, o:1'b1, z:1'b0};
        vecs[4] = '{a:32'h00000003, b:32'h00000005, s:1'b1, r:32'hFFFFFFFE, c:1'b0, o:1'b0, z:1'b0};

        // Reset in progress, then post-release values.
        #2;
        check("rst_in_ready_low", W'(in_ready), W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready",  W'(in_ready),  W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy",      W'(busy),      W'(0));
        check("rst_result",    result,        '0);
        check("rst_carry",     W'(carry),     W'(0));
        check("rst_overflow",  W'(overflow),  W'(0));
        check("rst_zero",      W'(zero),      W'(1));

        // Directed table.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, lat, ok);
            if (ok) begin
                check($sformatf("vec%0d_latency", i), W'(lat), W'(WORDS + 1));
                checkOutput(vecs[i], $sformatf("vec%0d", i));
                check($sformatf("vec%0d_busy", i), W'(busy), W'(1));
                drain($sformatf("vec%0d", i));
            end
        end

        // Backpressure: hold the result while a second request waits.
        model(32'h12345678, 32'h0FEDCBA9, 1'b0, v);
        model(32'h00000010, 32'h00000020, 1'b1, v2);
        applyStimulus(v.a, v.b, v.s, lat, ok);
        if (ok) begin
            in_valid = 1'b1;
            op_a = v2.a;
            op_b = v2.b;
            sub  = v2.s;
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                check($sformatf("bp%0d_out_valid", k), W'(out_valid), W'(1));
                check($sformatf("bp%0d_in_ready", k),  W'(in_ready),  W'(0));
                checkOutput(v, $sformatf("bp%0d", k));
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            check("bp_second_idle", W'(in_ready), W'(1));
            applyStimulus(v2.a, v2.b, v2.s, lat, ok);
            if (ok) begin
                checkOutput(v2, "bp_second");
                drain("bp_second");
            end
        end

        // Reset during RUN byte 2, then a fresh operation.
        in_valid = 1'b1;
        op_a = 32'hDEADBEEF;
        op_b = 32'h01010101;
        sub  = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",  W'(in_ready),  W'(0));
        check("midrst_out_valid", W'(out_valid), W'(0));
        check("midrst_busy",      W'(busy),      W'(0));
        check("midrst_result",    result,        '0);
        check("midrst_zero",      W'(zero),      W'(1));
        @(negedge clk) rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_never_valid", W'(out_valid), W'(0));
        end
        model(32'hCAFEF00D, 32'h0BADF00D, 1'b1, v);
        applyStimulus(v.a, v.b, v.s, lat, ok);
        if (ok) begin
            checkOutput(v, "postrst");
            drain("postrst");
        end

        // Randomized operations against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (n % 8 == 0) rb = ra;
            if (n % 8 == 1) ra = '1;
            model(ra, rb, 1'($urandom_range(0, 1)), v);
            applyStimulus(v.a, v.b, v.s, lat, ok);
            if (ok) begin
                check($sformatf("rnd%0d_latency", n), W'(lat), W'(WORDS + 1));
                checkOutput(v, $sformatf("rnd%0d", n));
                drain($sformatf("rnd%0d", n));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/addsub_seq_ctrl.md
# addsub_seq_ctrl

Sequencer that performs a WORDS×8-bit add or subtract by time-multiplexing a single 8-bit prefix adder, one byte per cycle, least-significant byte first. The carry is chained through a register between bytes. The block sits between the execute-stage issue logic and the ALU result mux, and exposes valid/ready handshakes on both sides. It also produces carry, signed-overflow and zero flags for the flags register.

## Interface
Parameters:
- WORDS, 4, number of 8-bit slices; operand width W = 8*WORDS; legal range 2..8.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low; one clock domain.
- in_valid  in  1  operand request valid.
- in_ready  out  1  block can accept a request.
- op_a  in  W  first operand.
- op_b  in  W  second operand.
- sub  in  1  1 = op_a − op_b, 0 = op_a + op_b.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  sum or difference, modulo 2^W.
- carry  out  1  carry-out of the MSB; for subtract, 1 = no borrow.
- overflow  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.
- busy  out  1  high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - in_ready = 1.
  - On in_valid & in_ready:
    - latch op_a.
    - latch op_b, XORed with {W{sub}}.
    - cin_reg ← sub.
    - idx ← 0.
    - go to RUN.
- **RUN**
  - Adder inputs:
    - A = a_reg[8*idx +: 8].
    - B = b_reg[8*idx +: 8].
    - Cin = cin_reg.
  - Each cycle:
    - res_reg[8*idx +: 8] ← Sum.
    - cin_reg ← Cout.
    - idx ← idx + 1.
  - On the last byte (idx == WORDS−1):
    - carry_reg ← Cout.
    - ovf_reg ← (A[7] == B[7]) & (Sum[7] != A[7]), using the post-inversion B byte.
    - go to DONE.
  - in_ready = 0 throughout.
- **DONE**
  - out_valid = 1.
  - result, carry, overflow and zero are held stable until out_valid & out_ready.
  - zero = (res_reg == 0), combinational from res_reg.
  - On out_ready, return to IDLE.
  - in_ready = 0 in DONE; there is no accept-while-draining.
- The width of idx is $clog2(WORDS).
- idx never wraps inside RUN: the last-byte compare forces the exit to DONE.
- The sub input is sampled only at accept. Changes to sub, op_a or op_b after accept have no effect.
- in_valid while busy: the request is not accepted and no state changes. The requester must hold it, per the standard valid/ready rule.
- out_ready while not out_valid: ignored.
- Reset (any state, including mid-RUN or in DONE), asserted asynchronously:
  - state = IDLE, idx = 0.
  - a_reg, b_reg, res_reg = 0.
  - cin_reg, carry_reg, ovf_reg = 0.
  - A partially computed result is discarded and never presented.
- Outputs while rst_n is low: in_ready = 0.
- Outputs after reset release:
  - in_ready = 1, out_valid = 0, busy = 0.
  - result = 0, carry = 0, overflow = 0, zero = 1.

## Timing
- Accept in cycle N.
- RUN occupies cycles N+1 .. N+WORDS, one byte per cycle.
- out_valid is high from cycle N+WORDS+1.
- Latency, accept to out_valid: WORDS+1 cycles (5 for WORDS=4).
- With out_ready held high, the DONE handshake takes 1 cycle, then IDLE takes 1 cycle. Peak throughput is one operation per WORDS+2 cycles.
- in_ready and out_valid are decoded from registered state only; there is no combinational path from in_valid or out_ready.
- The critical path is one 8-bit prefix adder plus byte-select mux plus register setup.

## Structure
- Shared package addsub_pkg:
  - state enum addsub_state_t {IDLE, RUN, DONE}.
  - localparam BYTE_W = 8.
- One sub-module instance: prefixadder_8bit.
  - Driven by the byte-select muxes and cin_reg.
  - Its Sum and Cout feed res_reg, cin_reg and the flag logic.
- No other hierarchy. All other logic is in a single always_ff and a single always_comb.

## Test plan
All cases use WORDS=4.
- **Add with byte carry.** 0x000000FF + 0x00000001, sub=0.
  - result 0x00000100, carry 0, overflow 0, zero 0.
  - out_valid exactly 5 cycles after accept.
- **Add with full wrap.** 0xFFFFFFFF + 0x00000001.
  - result 0x00000000, carry 1, overflow 0, zero 1.
- **Signed add overflow.** 0x7FFFFFFF + 0x00000001.
  - result 0x80000000, carry 0, overflow 1.
- **Subtract, signed overflow.** sub=1, 0x80000000 − 0x00000001.
  - result 0x7FFFFFFF, carry 1, overflow 1.
- **Subtract, borrow.** sub=1, 0x00000003 − 0x00000005.
  - result 0xFFFFFFFE, carry 0, overflow 0.
- **Backpressure and reset.**
  - Hold out_ready=0 for 3 cycles in DONE: result and flags stay stable, in_ready stays 0. A second in_valid is not accepted until after the out handshake.
  - Separately, drop rst_n during RUN byte 2: outputs go immediately to reset values, and a new request is accepted after release and completes correctly.
